// File: rtl/alu_pkg.sv
// Shared definitions for the ALU engines: default datapath width and the
// divider's FSM state encoding.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/alu_div_step.sv
// One restoring division step: shift the partial remainder left by one
// dividend bit, trial-subtract the divisor and keep the result if it fits.
module alu_div_step
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_dvd_bit,
    input  logic [WIDTH-1:0] i_dsr,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_qbit
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;

    // i_rem < i_dsr always holds, so the difference fits in WIDTH+1 bits and
    // its top bit is a clean borrow flag.
    assign w_shift = {i_rem, i_dvd_bit};
    assign w_diff  = w_shift - {1'b0, i_dsr};
    assign o_qbit  = ~w_diff[WIDTH];
    assign o_rem   = o_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];

endmodule

// File: rtl/alu_div.sv
// Multi-cycle signed/unsigned restoring divider: WIDTH magnitude steps,
// one sign-fix cycle, then a registered result with a one-cycle valid pulse.
module alu_div
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             start,
    input  logic             sgn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             dz
);

    localparam int               CNT_W     = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    div_state_e       r_state;
    div_state_e       w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dsr;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_dz_pend;
    logic             r_valid;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic             r_dz;

    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH-1:0] w_step_rem;
    logic             w_qbit;

    assign w_a_neg = sgn & a[WIDTH-1];
    assign w_b_neg = sgn & b[WIDTH-1];
    assign w_a_mag = w_a_neg ? -a : a;
    assign w_b_mag = w_b_neg ? -b : b;

    // r_quo starts as the dividend magnitude and fills with quotient bits as
    // the dividend bits are shifted out of its top.
    alu_div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem     (r_rem),
        .i_dvd_bit (r_quo[WIDTH-1]),
        .i_dsr     (r_dsr),
        .o_rem     (w_step_rem),
        .o_qbit    (w_qbit)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else if (ce) begin
            r_state <= w_next;
        end
    end

    // NOTE: default assignment first so no path leaves w_next unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_next = (b == '0) ? ST_DONE : ST_CALC;
            ST_CALC: if (r_cnt == LAST_STEP) w_next = ST_FIX;
            ST_FIX:  w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // busy stays up through the valid cycle even though the FSM is back in IDLE.
    always_comb begin
        busy  = (r_state != ST_IDLE) || r_valid;
        valid = r_valid;
        q     = r_q;
        r     = r_r;
        dz    = r_dz;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_quo     <= '0;
            r_rem     <= '0;
            r_dsr     <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_dz_pend <= 1'b0;
            r_valid   <= 1'b0;
            r_q       <= '0;
            r_r       <= '0;
            r_dz      <= 1'b0;
        end else if (ce) begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_cnt   <= '0;
                        r_dsr   <= w_b_mag;
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                        // Divide-by-zero skips the datapath; the result is preloaded.
                        if (b == '0) begin
                            r_quo     <= '1;
                            r_rem     <= a;
                            r_dz_pend <= 1'b1;
                        end else begin
                            r_quo     <= w_a_mag;
                            r_rem     <= '0;
                            r_dz_pend <= 1'b0;
                        end
                    end
                end
                ST_CALC: begin
                    r_rem <= w_step_rem;
                    r_quo <= {r_quo[WIDTH-2:0], w_qbit};
                    r_cnt <= r_cnt + 1'b1;
                end
                ST_FIX: begin
                    if (r_neg_q) r_quo <= -r_quo;
                    if (r_neg_r) r_rem <= -r_rem;
                end
                ST_DONE: begin
                    r_valid <= 1'b1;
                    r_q     <= r_quo;
                    r_r     <= r_rem;
                    r_dz    <= r_dz_pend;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/alu_div.md
ALU_DIV -- requirements
Module: alu_div

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port ce  input  1  clock enable; low freezes all state and outputs.
REQ-005 SHALL have port start  input  1  one-cycle request pulse; sampled only in IDLE with ce high.
REQ-006 SHALL have port sgn  input  1  1 = signed two's-complement divide, 0 = unsigned; sampled with start.
REQ-007 SHALL have port a  input  WIDTH  dividend; sampled with start.
REQ-008 SHALL have port b  input  WIDTH  divisor; sampled with start.
REQ-009 SHALL have port busy  output  1  high from the cycle after start acceptance until the cycle valid is asserted, inclusive.
REQ-010 SHALL have port valid  output  1  one-cycle pulse marking q/r/dz as new.
REQ-011 SHALL have port q  output  WIDTH  quotient.
REQ-012 SHALL have port r  output  WIDTH  remainder.
REQ-013 SHALL have port dz  output  1  divide-by-zero flag for the current result.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, FIX, DONE; all transitions occur only on edges where ce is high.
REQ-015 SHALL in IDLE, on start high: latch a, b, sgn; convert operands to magnitudes when sgn=1; record quotient and remainder signs; go to CALC, or to DONE if b = 0.
REQ-016 SHALL in CALC perform one restoring shift-subtract step per enabled cycle, exactly WIDTH steps, tracked by an iteration counter, then go to FIX.
REQ-017 SHALL in FIX negate quotient if sign(a) XOR sign(b) and negate remainder if sign(a), only when sgn=1, then go to DONE.
REQ-018 SHALL in DONE drive valid high for one cycle, update q/r/dz on the same edge, and return to IDLE.
REQ-019 SHALL produce valid exactly WIDTH+2 enabled cycles after the start-accepting edge for b != 0, and 1 enabled cycle after it for b = 0.
REQ-020 SHALL truncate quotient toward zero; remainder SHALL carry the sign of the dividend and satisfy a = q*b + r.
REQ-021 SHALL for b = 0 output q = all ones, r = a (unmodified), dz = 1; dz SHALL be 0 for all other results.
REQ-022 SHALL for sgn=1, a = most-negative value, b = -1 output q = most-negative value, r = 0, dz = 0 (wrap, no trap).
REQ-023 SHALL ignore start while not in IDLE; no queuing.
REQ-024 SHALL hold q, r, dz stable between valid pulses.
REQ-025 SHALL with ce low stall the counter and FSM without loss; latency in ce-high cycles is unchanged.

Reset
REQ-026 SHALL on rst asserted, at any time including mid-operation, enter IDLE with busy=0, valid=0, q=0, r=0, dz=0, counter=0.
REQ-027 SHALL discard any in-flight operation on reset; no valid pulse for it after rst deasserts.

Structure
REQ-028 SHALL take WIDTH default and FSM state encodings from shared package alu_pkg, which the ALU engine also uses.
REQ-029 SHALL place one restoring step (shift partial remainder, trial subtract, select, emit quotient bit) in combinational sub-module alu_div_step.
REQ-030 SHALL keep the iteration counter at clog2(WIDTH)+1 bits.

Verification
REQ-031 SHALL cover: sgn=0, a=100, b=7 -> valid at edge 34 (WIDTH=32), q=14, r=2, dz=0.
REQ-032 SHALL cover: sgn=1, a=-100, b=7 -> q=0xFFFFFFF2, r=0xFFFFFFFE; repeat with a=100, b=-7 -> q=0xFFFFFFF2, r=2.
REQ-033 SHALL cover: a=5, b=0 -> valid 1 cycle after acceptance, q=0xFFFFFFFF, r=5, dz=1.
REQ-034 SHALL cover: sgn=1, a=0x80000000, b=0xFFFFFFFF -> q=0x80000000, r=0, dz=0.
REQ-035 SHALL cover: ce low for 10 cycles during CALC, plus start pulses while busy -> single valid at edge 44, q/r correct.
REQ-036 SHALL cover: rst pulsed at CALC step 15 -> all outputs 0, no valid; next start 100/7 completes normally.
